ahb_sram_ctrl: RTL and testbench

- AHB-Lite slave that acts as the initiator for one port of the 4096x32 on-chip SRAM macro: CSN/ADDR/WE/BE/DI in, DO out, one-cycle registered read.
- Turns Cortex-M0 bus transfers into SRAM cycles: zero-wait word reads, zero-wait word writes, and read-modify-write for byte and halfword writes.
- Sits between the AHB decoder/mux and the SRAM instance.

---
 rtl/ahb_sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave fronting one port of the 4096x32 on-chip SRAM.
// Zero-wait word reads/writes; sub-word writes go through read-modify-write.
module ahb_sram_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              CSN,
    output logic [ADDR_W-1:0] ADDR,
    output logic              WE,
    output logic [3:0]        BE,
    output logic [31:0]       DI,
    input  logic [31:0]       DO
);

    // state  | meaning
    // IDLE   | no data phase in progress, port free
    // RD     | read data phase, DO returned on HRDATA, port free
    // WR     | word write data phase, write committed this cycle
    // RAW    | read arrived while port was busy writing; issue it now (wait)
    // RMW_RD | sub-word write: fetch the old word (wait)
    // RMW_WR | sub-word write: merge old word with HWDATA lanes and write
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RAW    = 3'd3,
        RMW_RD = 3'd4,
        RMW_WR = 3'd5
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q;
    logic [3:0]         mask_q;

    logic               accept;
    logic               port_free;
    logic [ADDR_W-1:0]  haddr_word;
    logic [3:0]         lane_mask;
    logic [31:0]        bit_mask;
    logic               unused_bits;

    assign accept      = HSEL & HTRANS[1] & HREADY;
    assign port_free   = (state == IDLE) || (state == RD);
    assign haddr_word  = HADDR[ADDR_W+1:2];
    assign bit_mask    = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
    assign HRESP       = 1'b0;
    assign unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

    always_comb begin
        case (HSIZE)
            3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
            3'd1:    lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'hF;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            mask_q  <= 4'h0;
        end else begin
            if (accept) begin
                addr_q  <= haddr_word;
                write_q <= HWRITE;
                mask_q  <= lane_mask;
            end
            case (state)
                IDLE, RD, WR, RMW_WR: begin
                    if (!accept)
                        state <= IDLE;
                    else if (!HWRITE)
                        state <= port_free ? RD : RAW;
                    else
                        state <= (lane_mask == 4'hF) ? WR : RMW_RD;
                end
                RAW:     state <= RD;
                RMW_RD:  state <= RMW_WR;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        CSN       = 1'b1;
        WE        = 1'b0;
        BE        = 4'h0;
        DI        = 32'h0;
        ADDR      = '0;
        HRDATA    = 32'h0;
        HREADYOUT = 1'b1;
        case (state)
            IDLE, RD: begin
                if (state == RD)
                    HRDATA = DO;
                // a read landing on a free port is issued in its own address phase
                if (accept && !HWRITE) begin
                    CSN  = 1'b0;
                    BE   = 4'hF;
                    ADDR = haddr_word;
                end
            end
            WR: begin
                CSN  = 1'b0;
                WE   = write_q;
                BE   = 4'hF;
                ADDR = addr_q;
                DI   = HWDATA;
            end
            RAW, RMW_RD: begin
                CSN       = 1'b0;
                BE        = 4'hF;
                ADDR      = addr_q;
                HREADYOUT = 1'b0;
            end
            RMW_WR: begin
                CSN  = 1'b0;
                WE   = write_q;
                BE   = 4'hF;
                ADDR = addr_q;
                DI   = (DO & ~bit_mask) | (HWDATA & bit_mask);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: pipelined AHB master, behavioural SRAM and a
// program-order reference memory feeding an expected-read-data queue.
module tb_ahb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        csn;
    logic [11:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] di;
    logic [31:0] sram_do;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahb_sram_ctrl #(.ADDR_W(12)) dut (
        .CLK(clk), .RESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .CSN(csn),
        .ADDR(addr), .WE(we), .BE(be), .DI(di), .DO(sram_do)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // behavioural SRAM with one-cycle registered read
    bit [31:0]   sram [4096];
    int          wr_count = 0;
    logic [11:0] last_wr_addr = '0;
    logic [31:0] last_wr_di = '0;

    always @(posedge clk) begin
        if (!csn) begin
            check_eq("sram_be", {28'h0, be}, 32'hF);
            if (we) begin
                sram[addr]   <= di;
                wr_count     = wr_count + 1;
                last_wr_addr = addr;
                last_wr_di   = di;
            end
            sram_do <= sram[addr];
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       pend [$];
    logic [31:0] exp_q [$];
    bit   [31:0] ref_mem [4096];
    xfer_t       cur, dp;
    logic        addr_valid = 1'b0;
    logic        dp_valid = 1'b0;

    function automatic logic [31:0] bits_of(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << a;
            3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'hF;
        endcase
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic push(input logic wr, input logic [31:0] a, input logic [2:0] size,
                        input logic [31:0] wdata);
        xfer_t x;
        x.wr = wr; x.a = a; x.size = size; x.wdata = wdata;
        pend.push_back(x);
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = '0;
    endtask

    task automatic run_seq(output int waits);
        int   budget;
        logic rdy;
        logic [31:0] m;
        budget = 0;
        waits  = 0;
        while ((pend.size() != 0 || addr_valid || dp_valid) && budget < 200) begin
            @(negedge clk);
            rdy = hreadyout;
            if (!rdy) waits++;
            if (dp_valid && rdy && !dp.wr) begin
                if (exp_q.size() == 0) check_eq("exp_q_empty", hrdata, 32'hx);
                else check_eq("hrdata", hrdata, exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                dp_valid = addr_valid;
                dp       = cur;
                hwdata   = (addr_valid && cur.wr) ? cur.wdata : 32'h0;
                if (pend.size() != 0) begin
                    cur = pend.pop_front();
                    addr_valid = 1'b1;
                    hsel = 1'b1; htrans = 2'b10; hwrite = cur.wr;
                    hsize = cur.size; haddr = cur.a;
                    if (cur.wr) begin
                        m = bits_of(cur.size, cur.a[1:0]);
                        ref_mem[cur.a[13:2]] = (ref_mem[cur.a[13:2]] & ~m) | (cur.wdata & m);
                    end else begin
                        exp_q.push_back(ref_mem[cur.a[13:2]]);
                    end
                end else begin
                    addr_valid = 1'b0;
                    bus_idle();
                end
            end
            budget++;
        end
        check_eq("seq_done", {31'h0, budget < 200}, 32'h1);
    endtask

    int   w;
    int   wc;
    logic rw;
    logic [2:0]  sz;
    logic [31:0] ra;

    initial begin
        rst_n  = 1'b0;
        hwdata = 32'h0;
        bus_idle();
        #2;
        check_eq("rst_hreadyout", {31'h0, hreadyout}, 32'h1);
        check_eq("rst_csn", {31'h0, csn}, 32'h1);
        check_eq("rst_we", {31'h0, we}, 32'h0);
        check_eq("rst_hrdata", hrdata, 32'h0);
        check_eq("rst_hresp", {31'h0, hresp}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // word write then separate word read, both zero-wait
        push(1, 32'h10, 3'd2, 32'hDEADBEEF);
        run_seq(w);
        check_eq("w1_waits", w, 0);
        check_eq("w1_addr", {20'h0, last_wr_addr}, 32'h4);
        check_eq("w1_di", last_wr_di, 32'hDEADBEEF);
        push(0, 32'h10, 3'd2, 32'h0);
        run_seq(w);
        check_eq("r1_waits", w, 0);

        // write immediately followed by read of the same word
        push(1, 32'h20, 3'd2, 32'h11223344);
        push(0, 32'h20, 3'd2, 32'h0);
        run_seq(w);
        check_eq("raw_waits", w, 1);

        // byte RMW
        push(1, 32'h30, 3'd2, 32'hAABBCCDD);
        run_seq(w);
        push(1, 32'h31, 3'd0, 32'h0000EE00);
        run_seq(w);
        check_eq("byte_waits", w, 1);
        check_eq("byte_di", last_wr_di, 32'hAABBEEDD);
        check_eq("byte_addr", {20'h0, last_wr_addr}, 32'hC);
        push(0, 32'h30, 3'd2, 32'h0);
        run_seq(w);

        // halfword RMW
        push(1, 32'h32, 3'd1, 32'h12340000);
        run_seq(w);
        check_eq("half_waits", w, 1);
        check_eq("half_di", last_wr_di, 32'h1234EEDD);
        push(0, 32'h30, 3'd2, 32'h0);
        run_seq(w);

        // back-to-back writes then back-to-back reads
        push(1, 32'h00, 3'd2, 32'h01010101);
        push(1, 32'h04, 3'd2, 32'h02020202);
        push(1, 32'h08, 3'd2, 32'h03030303);
        run_seq(w);
        check_eq("bbw_waits", w, 0);
        push(0, 32'h00, 3'd2, 32'h0);
        push(0, 32'h04, 3'd2, 32'h0);
        push(0, 32'h08, 3'd2, 32'h0);
        run_seq(w);
        check_eq("bbr_waits", w, 0);

        // unselected request must not touch the SRAM
        hsel = 1'b0; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h10;
        @(negedge clk);
        check_eq("unsel_csn", {31'h0, csn}, 32'h1);
        check_eq("idle_hrdata", hrdata, 32'h0);
        @(posedge clk); #1;
        bus_idle();

        // mixed random traffic
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 2));
            ra = 32'h100 + 32'($urandom_range(0, 31));
            if (sz == 3'd1) ra[0] = 1'b0;
            if (sz == 3'd2) ra[1:0] = 2'b00;
            push(rw, ra, sz, $urandom);
        end
        run_seq(w);

        // reset in the middle of a read-modify-write
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd0; haddr = 32'h33;
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'h99000000;
        check_eq("rmw_wait", {31'h0, hreadyout}, 32'h0);
        wc = wr_count;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rrst_hreadyout", {31'h0, hreadyout}, 32'h1);
        check_eq("rrst_csn", {31'h0, csn}, 32'h1);
        check_eq("rrst_we", {31'h0, we}, 32'h0);
        check_eq("rrst_hrdata", hrdata, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rrst_no_write", wc, wr_count);
        push(0, 32'h30, 3'd2, 32'h0);
        run_seq(w);
        check_eq("rrst_sram_word", sram[12'hC], 32'h1234EEDD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
